// File: rtl/huffman_pack.sv
// Huffman code packer: maps symbols to table-configured codes (1..W bits) and packs them
// MSB-first, gap-free, into W-bit words; flush pads the last partial word with PAD bits.
module huffman_pack #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter bit PAD   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_in,
    input  logic         en_in,
    output logic         d_req,
    input  logic         flush,
    input  logic [W-1:0] d_conf,
    input  logic [W-1:0] h_conf,
    input  logic [W-1:0] w_conf,
    input  logic         en_conf,
    input  logic         new_conf,
    output logic [W-1:0] d_out,
    output logic         en_out,
    input  logic         ready_out,
    output logic         err,
    output logic         conf_full
);
    localparam int FW = $clog2(2 * W + 1);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [FW-1:0] W_F     = FW'(W);
    localparam logic [FW-1:0] TWO_W   = FW'(2 * W);
    localparam logic [W-1:0]  W_MAX   = W'(W);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    typedef enum logic [1:0] {EMPTY, RUN, FLUSH} state_t;

    state_t           state, state_n;
    logic [W-1:0]     tab_d [DEPTH];
    logic [W-1:0]     tab_h [DEPTH];
    logic [W-1:0]     tab_w [DEPTH];
    logic [DEPTH-1:0] tab_v;
    logic [PW-1:0]    wr_ptr;
    logic [AW-1:0]    wr_idx;
    logic [2*W-1:0]   acc, acc_n, code_ext;
    logic [FW-1:0]    fill, fill_n, hit_wf;
    logic [W-1:0]     hit_h, hit_w, word;
    logic             hit, accept, out_free, emit, conf_ok;

    assign wr_idx  = wr_ptr[AW-1:0];
    assign conf_ok = en_conf && !new_conf && (w_conf != '0) && (w_conf <= W_MAX)
                     && (wr_ptr < DEPTH_P);

    // NOTE: every always_comb output gets a default before any branch, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        hit   = 1'b0;
        hit_h = '0;
        hit_w = '0;
        // Scan downward so the lowest matching index is the last one written.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tab_v[i] && (tab_d[i] == d_in)) begin
                hit   = 1'b1;
                hit_h = tab_h[i];
                hit_w = tab_w[i];
            end
        end
    end

    assign hit_wf   = FW'(hit_w);
    assign code_ext = {{W{1'b0}}, hit_h & ~({W{1'b1}} << hit_w)};

    // NOTE: combinational blocks use blocking '=' so later statements see earlier results
    // (emit first, then append on top of the post-emit accumulator); flops use '<='.
    always_comb begin
        accept   = en_in && d_req;
        out_free = !en_out || ready_out;
        emit     = 1'b0;
        word     = acc[2*W-1:W];
        acc_n    = acc;
        fill_n   = fill;
        state_n  = state;
        if (state == FLUSH) begin
            if (fill >= W_F) begin
                if (out_free) begin
                    emit   = 1'b1;
                    acc_n  = acc << W;
                    fill_n = fill - W_F;
                end
            end else if (fill == '0) begin
                state_n = RUN;
            end else if (out_free) begin
                emit    = 1'b1;
                word    = acc[2*W-1:W] | (PAD ? ({W{1'b1}} >> fill) : '0);
                acc_n   = '0;
                fill_n  = '0;
                state_n = RUN;
            end
        end else begin
            if ((fill >= W_F) && out_free) begin
                emit   = 1'b1;
                acc_n  = acc << W;
                fill_n = fill - W_F;
            end
            if (accept && hit) begin
                acc_n  = acc_n | (code_ext << (TWO_W - fill_n - hit_wf));
                fill_n = fill_n + hit_wf;
            end
            if ((state == RUN) && flush && (fill_n != '0)) state_n = FLUSH;
            if ((state == EMPTY) && conf_ok) state_n = RUN;
        end
    end

    // NOTE: table contents are not reset; only the valid bits are, which is all a lookup
    // depends on, so the storage can map to plain RAM-style flops.
    always_ff @(posedge clk) begin
        if (conf_ok) begin
            tab_d[wr_idx] <= d_conf;
            tab_h[wr_idx] <= h_conf;
            tab_w[wr_idx] <= w_conf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || new_conf) begin
            tab_v     <= '0;
            wr_ptr    <= '0;
            conf_full <= 1'b0;
            acc       <= '0;
            fill      <= '0;
            state     <= EMPTY;
            d_out     <= '0;
            en_out    <= 1'b0;
            err       <= 1'b0;
            d_req     <= 1'b0;
        end else begin
            if (conf_ok) begin
                tab_v[wr_idx] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            conf_full <= ((wr_ptr + PW'(conf_ok)) == DEPTH_P);
            acc       <= acc_n;
            fill      <= fill_n;
            state     <= state_n;
            d_req     <= (state_n == RUN) && (fill_n <= W_F);
            err       <= accept && !hit;
            if (emit) begin
                d_out  <= word;
                en_out <= 1'b1;
            end else if (ready_out) begin
                en_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_huffman_pack.sv
// Self-checking bench for huffman_pack: constant vectors, hand sequences for stall/flush/clear,
// and a randomized run compared against a bit-queue model of the packed stream.
module tb_huffman_pack;
    logic       clk, rst, en_in, flush, en_conf, new_conf, ready_out;
    logic [7:0] d_in, d_conf, h_conf, w_conf;
    logic       d_req, en_out, err, conf_full;
    logic [7:0] d_out;

    huffman_pack #(.W(8), .DEPTH(16), .PAD(1'b1)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in), .d_req(d_req), .flush(flush),
        .d_conf(d_conf), .h_conf(h_conf), .w_conf(w_conf), .en_conf(en_conf),
        .new_conf(new_conf), .d_out(d_out), .en_out(en_out), .ready_out(ready_out),
        .err(err), .conf_full(conf_full)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: config table as written, and the expected stream as a bit queue
    logic [7:0] m_d [16];
    logic [7:0] m_h [16];
    int         m_w [16];
    int         m_cnt;
    bit         m_bits [$];
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    logic       clr, prev_stall, done;
    logic [7:0] prev_word;
    logic [7:0] scodes [10];

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] w;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [9];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Capture handshakes and verify the output holds steady while stalled.
    always @(negedge clk) begin
        if (en_out && ready_out) got.push_back(d_out);
        if (prev_stall && !clr) check("hold", {23'd0, en_out, d_out}, {23'd0, 1'b1, prev_word});
        prev_stall = en_out && !ready_out;
        prev_word  = d_out;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all;
        clr      = 1'b1;
        new_conf = 1'b1;
        tick();
        new_conf = 1'b0;
        m_cnt    = 0;
        m_bits.delete();
        tick();
        clr = 1'b0;
        got.delete();
        exp_q.delete();
    endtask

    task automatic do_reset;
        clr = 1'b1;
        rst = 1'b0;
        tick();
        rst   = 1'b1;
        m_cnt = 0;
        m_bits.delete();
        tick();
        clr = 1'b0;
        got.delete();
        exp_q.delete();
    endtask

    task automatic conf(input logic [7:0] d, input logic [7:0] h, input logic [7:0] w);
        d_conf  = d;
        h_conf  = h;
        w_conf  = w;
        en_conf = 1'b1;
        tick();
        en_conf = 1'b0;
        if (w >= 8'd1 && w <= 8'd8 && m_cnt < 16) begin
            m_d[m_cnt] = d;
            m_h[m_cnt] = h;
            m_w[m_cnt] = int'(w);
            m_cnt++;
        end
    endtask

    task automatic send(input logic [7:0] s);
        int n;
        int idx;
        n = 0;
        while (!d_req && n < 300) begin
            tick();
            n++;
        end
        if (!d_req) begin
            check("d_req_wait", {31'd0, d_req}, 32'd1);
            return;
        end
        d_in  = s;
        en_in = 1'b1;
        tick();
        en_in = 1'b0;
        idx   = -1;
        for (int i = 0; i < m_cnt; i++) if (idx < 0 && m_d[i] == s) idx = i;
        check("err", {31'd0, err}, {31'd0, idx < 0});
        if (idx >= 0) for (int b = m_w[idx] - 1; b >= 0; b--) m_bits.push_back(m_h[idx][b]);
    endtask

    task automatic do_flush;
        int n;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        while (m_bits.size() % 8 != 0) m_bits.push_back(1'b1);
        n = 0;
        while (!d_req && n < 300) begin
            tick();
            n++;
        end
        if (!d_req) check("flush_done", {31'd0, d_req}, 32'd1);
    endtask

    task automatic model_take;
        logic [7:0] wv;
        while (m_bits.size() >= 8) begin
            wv = '0;
            for (int b = 0; b < 8; b++) wv = {wv[6:0], m_bits.pop_front()};
            exp_q.push_back(wv);
        end
    endtask

    task automatic check_words(input string name);
        int n;
        n = 0;
        while (got.size() < exp_q.size() && n < 1000) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check(name, {24'd0, got[i]}, {24'd0, exp_q[i]});
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{8'h01, 8'd1, 8'hFF};
        vecs[1] = '{8'h00, 8'd1, 8'h7F};
        vecs[2] = '{8'h04, 8'd3, 8'h9F};
        vecs[3] = '{8'h00, 8'd8, 8'h00};
        vecs[4] = '{8'h5A, 8'd8, 8'h5A};
        vecs[5] = '{8'h05, 8'd4, 8'h5F};
        vecs[6] = '{8'hF3, 8'd4, 8'h3F};
        vecs[7] = '{8'h00, 8'd6, 8'h03};
        vecs[8] = '{8'h55, 8'd7, 8'hAB};
        scodes  = '{8'h3C, 8'hA5, 8'h00, 8'hFE, 8'h81, 8'h5A, 8'h17, 8'hC3, 8'h6E, 8'h99};

        rst = 1'b0; en_in = 1'b0; flush = 1'b0; en_conf = 1'b0; new_conf = 1'b0;
        ready_out = 1'b1; d_in = '0; d_conf = '0; h_conf = '0; w_conf = '0;
        clr = 1'b1; prev_stall = 1'b0; prev_word = '0; done = 1'b0; m_cnt = 0;
        repeat (3) tick();
        check("rst_d_out", {24'd0, d_out}, 32'd0);
        check("rst_en_out", {31'd0, en_out}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_d_req", {31'd0, d_req}, 32'd0);
        check("rst_conf_full", {31'd0, conf_full}, 32'd0);
        rst = 1'b1;
        tick();
        clr = 1'b0;
        check("empty_d_req", {31'd0, d_req}, 32'd0);

        // single code of each width, padded on flush
        for (int i = 0; i < 9; i++) begin
            clear_all();
            conf(8'h40, vecs[i].h, vecs[i].w);
            send(8'h40);
            do_flush();
            check("vec_d_req", {31'd0, d_req}, 32'd1);
            exp_q.push_back(vecs[i].exp);
            check_words($sformatf("vec%0d", i));
        end

        // T1
        clear_all();
        conf(8'h20, 8'h0, 8'd2);
        conf(8'h21, 8'h1, 8'd2);
        send(8'h20); send(8'h21); send(8'h20); send(8'h21);
        exp_q.push_back(8'h11);
        check_words("t1");

        // T2
        clear_all();
        conf(8'h30, 8'h4, 8'd3);
        conf(8'h31, 8'h5, 8'd3);
        for (int i = 0; i < 4; i++) begin
            send(8'h30);
            send(8'h31);
        end
        exp_q.push_back(8'h96); exp_q.push_back(8'h59); exp_q.push_back(8'h65);
        check_words("t2");

        // T3
        clear_all();
        conf(8'h30, 8'h04, 8'd3);
        conf(8'h81, 8'hFD, 8'd8);
        conf(8'h51, 8'h1D, 8'd5);
        send(8'h30); send(8'h81); send(8'h51);
        exp_q.push_back(8'h9F); exp_q.push_back(8'hBD);
        check_words("t3");

        // T4 and T5 miss
        clear_all();
        conf(8'h30, 8'h04, 8'd3);
        send(8'h99);
        tick();
        check("err_pulse_end", {31'd0, err}, 32'd0);
        repeat (3) tick();
        check("miss_no_word", {31'd0, en_out}, 32'd0);
        send(8'h30);
        do_flush();
        check("t4_d_req", {31'd0, d_req}, 32'd1);
        exp_q.push_back(8'h9F);
        check_words("t4");

        // T5 backpressure with 10 full-width codes
        clear_all();
        for (int i = 0; i < 10; i++) conf(8'hA0 + 8'(i), scodes[i], 8'd8);
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i));
        repeat (5) tick();
        check("stall_d_req", {31'd0, d_req}, 32'd0);
        check("stall_word", {23'd0, en_out, d_out}, {23'd0, 1'b1, scodes[0]});
        ready_out = 1'b1;
        for (int i = 3; i < 10; i++) send(8'hA0 + 8'(i));
        model_take();
        check_words("t5");

        // duplicate symbol: lowest index wins
        clear_all();
        conf(8'h10, 8'h1, 8'd1);
        conf(8'h10, 8'h0, 8'd1);
        for (int i = 0; i < 8; i++) send(8'h10);
        exp_q.push_back(8'hFF);
        check_words("dup");

        // config rules: bad widths, new_conf priority, full table
        clear_all();
        conf(8'h10, 8'h1, 8'd0);
        conf(8'h11, 8'h1, 8'd9);
        check("bad_w_d_req", {31'd0, d_req}, 32'd0);
        d_conf = 8'h12; h_conf = 8'h1; w_conf = 8'd1; en_conf = 1'b1; new_conf = 1'b1;
        tick();
        en_conf = 1'b0; new_conf = 1'b0;
        tick();
        check("prio_d_req", {31'd0, d_req}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            conf(8'(i), 8'(i), 8'd4);
            if (i == 14) check("conf_full_15", {31'd0, conf_full}, 32'd0);
        end
        check("conf_full_16", {31'd0, conf_full}, 32'd1);
        conf(8'h77, 8'h1, 8'd1);
        check("conf_full_hold", {31'd0, conf_full}, 32'd1);
        send(8'h77);
        send(8'h12);
        send(8'h03);
        send(8'h0C);
        model_take();
        check_words("full");

        // T6: new_conf mid-word
        clear_all();
        conf(8'h30, 8'h04, 8'd3);
        send(8'h30);
        clear_all();
        check("nc_en_out", {31'd0, en_out}, 32'd0);
        repeat (3) tick();
        check("nc_d_req", {31'd0, d_req}, 32'd0);
        conf(8'h30, 8'h04, 8'd3);
        send(8'h30);
        do_flush();
        exp_q.push_back(8'h9F);
        check_words("t6_nc");

        // T6: reset with a stalled word pending
        clear_all();
        for (int i = 0; i < 3; i++) conf(8'hA0 + 8'(i), scodes[i], 8'd8);
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i));
        do_reset();
        check("rr_en_out", {31'd0, en_out}, 32'd0);
        check("rr_d_req", {31'd0, d_req}, 32'd0);
        check("rr_conf_full", {31'd0, conf_full}, 32'd0);
        ready_out = 1'b1;
        check_words("t6_rst");

        // randomized table, stream, flushes and backpressure
        clear_all();
        for (int i = 0; i < 18; i++)
            conf(8'($urandom_range(0, 23)), 8'($urandom),
                 (i == 0) ? 8'($urandom_range(1, 8)) : 8'($urandom_range(0, 9)));
        check("rand_conf_full", {31'd0, conf_full}, {31'd0, m_cnt == 16});
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    if ($urandom_range(0, 19) == 0) do_flush();
                    else send(8'($urandom_range(0, 27)));
                end
                do_flush();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    ready_out = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready_out = 1'b1;
        model_take();
        check_words("rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
